fpu_move_pipe: RTL and testbench
================================

FPU_MOVE_PIPE -- requirements
Module: fpu_move_pipe

Interface
REQ-001 SHALL have parameter Std, default 31, data MSB index (data width Std+1).
REQ-002 SHALL have parameter Depth, default 2, output buffer entries (fixed 2 for this revision).
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, asynchronous and active-high.
REQ-005 flush  input  1  synchronous discard of all buffered moves.
REQ-006 in_valid  input  1  move request present.
REQ-007 in_ready  output  1  request accepted when in_valid & in_ready.
REQ-008 in_opcode  input  2  01 = FP->INT (fmv.x), 10 = INT->FP (fmv.w), 00/11 illegal.
REQ-009 in_data  input  Std+1  source register value.
REQ-010 in_rd  input  5  destination register index, carried unmodified.
REQ-011 out_valid  output  1  buffered result present at head.
REQ-012 out_ready  input  1  consumer takes head when out_valid & out_ready.
REQ-013 out_data  output  Std+1  moved value at head.
REQ-014 out_rd  output  5  destination index at head.
REQ-015 out_to_fp  output  1  1 = write FP register file, 0 = write integer register file.
REQ-016 out_illegal  output  1  head entry came from illegal opcode.
REQ-017 illegal_cnt  output  8  saturating count of accepted illegal requests.

Function
REQ-018 SHALL hold a 2-entry FIFO of {data, rd, to_fp, illegal}; occupancy 0..2.
REQ-019 in_ready SHALL equal (occupancy < 2) & ~flush, combinational from registered state and flush only.
REQ-020 Push on accept; out_* SHALL present the new entry no earlier than the cycle after acceptance (latency 1, no combinational in->out path).
REQ-021 Opcode 01: data = in_data, to_fp = 0, illegal = 0.
REQ-022 Opcode 10: data = in_data, to_fp = 1, illegal = 0.
REQ-023 Opcode 00/11: data = all zeros, to_fp = 0, illegal = 1; entry still queued and returned in order.
REQ-024 out_valid SHALL equal (occupancy != 0); out_* SHALL be zero when out_valid = 0.
REQ-025 Pop when out_valid & out_ready; FIFO SHALL preserve acceptance order.
REQ-026 Simultaneous push and pop SHALL leave occupancy unchanged; at occupancy 1 the pushed entry becomes head next cycle.
REQ-027 At occupancy 2, in_ready = 0; a pop in that cycle SHALL NOT admit a same-cycle push (no bypass).
REQ-028 Read/write pointers SHALL wrap modulo 2 with no loss or duplication.
REQ-029 flush SHALL take priority over push and pop: next cycle occupancy = 0, pointers = 0, out_valid = 0; no request accepted during flush.
REQ-030 illegal_cnt SHALL increment by 1 per accepted illegal request, saturating at 255; flush SHALL NOT clear it.
REQ-031 Out_* SHALL be stable while out_valid = 1 and out_ready = 0.

Reset
REQ-032 rst asserted SHALL immediately clear occupancy, pointers, illegal_cnt and all FIFO entries, regardless of clk.
REQ-033 During and after reset: out_valid = 0, out_data = 0, out_rd = 0, out_to_fp = 0, out_illegal = 0, illegal_cnt = 0, in_ready = 1 (unless flush).
REQ-034 Reset mid-transfer SHALL discard all buffered entries; first post-reset accept behaves as from empty.

Verification
REQ-035 Opcode 01, in_data 0x3F80_0000, rd 5, out_ready 1 -> next cycle out_valid 1, out_data 0x3F800000, out_rd 5, out_to_fp 0, out_illegal 0.
REQ-036 Opcode 10, data 0x0000_4049, rd 3 then opcode 01, data 0xC000_0000, rd 7, out_ready 0 -> occupancy 2, in_ready 0; raise out_ready -> rd 3 (to_fp 1) then rd 7 (to_fp 0) in order.
REQ-037 FIFO full, out_ready 1, in_valid 1 -> pop occurs, no push that cycle; request accepted next cycle; 10 back-to-back moves with random out_ready all returned in order.
REQ-038 Opcode 11, data 0xFFFF_FFFF -> out_data 0, out_illegal 1, illegal_cnt 1; 300 illegal requests -> illegal_cnt 255.
REQ-039 Occupancy 2, flush 1 with in_valid 1 -> in_ready 0 that cycle, out_valid 0 next cycle, illegal_cnt unchanged.
REQ-040 rst asserted asynchronously between edges with occupancy 1 -> out_valid 0 immediately; after release accepted move appears with latency 1.

Source files
------------

// File: rtl/fpu_move_pipe.sv
// FP<->INT register move unit: classifies each move request and buffers the
// result in a small in-order FIFO, decoupling the issue side from writeback.
`timescale 1ns/1ps
module fpu_move_pipe #(
    parameter int unsigned Std   = 31,
    parameter int unsigned Depth = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         flush,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [1:0]   in_opcode,
    input  logic [Std:0] in_data,
    input  logic [4:0]   in_rd,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [Std:0] out_data,
    output logic [4:0]   out_rd,
    output logic         out_to_fp,
    output logic         out_illegal,
    output logic [7:0]   illegal_cnt
);

    localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
    localparam int unsigned CntW = $clog2(Depth + 1);
    localparam int unsigned DW   = Std + 1;

    typedef struct packed {
        logic [Std:0] data;
        logic [4:0]   rd;
        logic         to_fp;
        logic         illegal;
    } entry_t;

    entry_t            mem [Depth];
    logic [PtrW-1:0]   wr_ptr;
    logic [PtrW-1:0]   rd_ptr;
    logic [CntW-1:0]   count;
    entry_t            new_entry;
    entry_t            head;
    logic              push;
    logic              pop;

    // Ready depends only on registered occupancy and flush, so a pop never
    // frees a slot for a push in the same cycle.
    assign in_ready  = (count < CntW'(Depth)) & ~flush;
    assign out_valid = (count != '0);
    assign push      = in_valid & in_ready;
    assign pop       = out_valid & out_ready & ~flush;

    // Opcode classification; illegal opcodes still occupy a slot with zeroed data.
    always_comb begin
        new_entry       = '0;
        new_entry.rd    = in_rd;
        case (in_opcode)
            2'b01: new_entry.data = in_data;
            2'b10: begin
                new_entry.data  = in_data;
                new_entry.to_fp = 1'b1;
            end
            default: new_entry.illegal = 1'b1;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count       <= '0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            illegal_cnt <= '0;
            for (int i = 0; i < Depth; i++) begin
                mem[i] <= '0;
            end
        end else if (flush) begin
            count  <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= new_entry;
                wr_ptr      <= (wr_ptr == PtrW'(Depth - 1)) ? '0 : wr_ptr + PtrW'(1);
                if (new_entry.illegal && illegal_cnt != 8'hFF) begin
                    illegal_cnt <= illegal_cnt + 8'd1;
                end
            end
            if (pop) begin
                rd_ptr <= (rd_ptr == PtrW'(Depth - 1)) ? '0 : rd_ptr + PtrW'(1);
            end
            count <= count + CntW'(push) - CntW'(pop);
        end
    end

    // Head fields are forced to zero whenever the buffer is empty.
    assign head        = mem[rd_ptr];
    assign out_data    = out_valid ? head.data : DW'(0);
    assign out_rd      = out_valid ? head.rd : 5'd0;
    assign out_to_fp   = out_valid & head.to_fp;
    assign out_illegal = out_valid & head.illegal;

endmodule

// File: tb/tb_fpu_move_pipe.sv
// Randomized self-checking bench for fpu_move_pipe against a queue-based model.
`timescale 1ns/1ps
module tb_fpu_move_pipe;

    logic        clk = 1'b0;
    logic        rst, flush, in_valid, in_ready, out_valid, out_ready;
    logic [1:0]  in_opcode;
    logic [31:0] in_data, out_data;
    logic [4:0]  in_rd, out_rd;
    logic        out_to_fp, out_illegal;
    logic [7:0]  illegal_cnt;

    int total = 0;
    int bad   = 0;

    fpu_move_pipe dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_opcode(in_opcode),
        .in_data(in_data), .in_rd(in_rd),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_rd(out_rd), .out_to_fp(out_to_fp), .out_illegal(out_illegal),
        .illegal_cnt(illegal_cnt)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] data;
        logic [4:0]  rd;
        logic        to_fp;
        logic        illegal;
    } ent_t;

    ent_t q[$];
    int   ill;
    logic obs_ready, exp_ready, obs_pre_valid, last_acc;

    logic [47:0] dut_vec;
    assign dut_vec = {out_valid, out_data, out_rd, out_to_fp, out_illegal, illegal_cnt};

    function automatic ent_t make(input logic [1:0] op, input logic [31:0] d, input logic [4:0] r);
        ent_t e;
        e.rd = r;
        if (op == 2'b01)      begin e.data = d;  e.to_fp = 1'b0; e.illegal = 1'b0; end
        else if (op == 2'b10) begin e.data = d;  e.to_fp = 1'b1; e.illegal = 1'b0; end
        else                  begin e.data = '0; e.to_fp = 1'b0; e.illegal = 1'b1; end
        return e;
    endfunction

    function automatic logic [47:0] exp_vec();
        if (q.size() == 0) return {1'b0, 32'd0, 5'd0, 1'b0, 1'b0, 8'(ill)};
        return {1'b1, q[0].data, q[0].rd, q[0].to_fp, q[0].illegal, 8'(ill)};
    endfunction

    // One clock of stimulus; starts and ends just after a falling edge.
    task automatic cycle(input logic v, input logic [1:0] op, input logic [31:0] d,
                         input logic [4:0] r, input logic ordy, input logic fl);
        logic pop;
        in_valid = v; in_opcode = op; in_data = d; in_rd = r; out_ready = ordy; flush = fl;
        #1;
        obs_ready     = in_ready;
        obs_pre_valid = out_valid;
        exp_ready     = (q.size() < 2) && !fl;
        last_acc      = v && exp_ready;
        pop           = (q.size() > 0) && ordy && !fl;
        @(posedge clk);
        if (fl) q.delete();
        else begin
            if (pop) void'(q.pop_front());
            if (last_acc) begin
                q.push_back(make(op, d, r));
                if (op inside {2'b00, 2'b11} && ill < 255) ill++;
            end
        end
        @(negedge clk);
        in_valid = 1'b0; flush = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0;
        in_opcode = 2'b00; in_data = '0; in_rd = '0;
        q.delete(); ill = 0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        do_reset();
        total++;
        if (dut_vec !== 48'd0) begin bad++; $display("FAIL reset_outputs got=%h want=%h", dut_vec, 48'd0); end
        total++;
        if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%b want=1", in_ready); end
        @(negedge clk);
    endtask

    task automatic test_basic();
        cycle(1'b1, 2'b01, 32'h3F80_0000, 5'd5, 1'b1, 1'b0);
        total++;
        if (obs_pre_valid !== 1'b0) begin bad++; $display("FAIL basic_latency got=%b want=0", obs_pre_valid); end
        total++;
        if (dut_vec !== {1'b1, 32'h3F80_0000, 5'd5, 1'b0, 1'b0, 8'd0}) begin
            bad++; $display("FAIL basic_fmvx got=%h want=%h", dut_vec, {1'b1, 32'h3F80_0000, 5'd5, 1'b0, 1'b0, 8'd0});
        end
        cycle(1'b0, 2'b00, 32'd0, 5'd0, 1'b1, 1'b0);
        total++;
        if (out_valid !== 1'b0) begin bad++; $display("FAIL basic_drain got=%b want=0", out_valid); end
    endtask

    task automatic test_order();
        cycle(1'b1, 2'b10, 32'h0000_4049, 5'd3, 1'b0, 1'b0);
        cycle(1'b1, 2'b01, 32'hC000_0000, 5'd7, 1'b0, 1'b0);
        #1;
        total++;
        if (in_ready !== 1'b0) begin bad++; $display("FAIL order_full_ready got=%b want=0", in_ready); end
        total++;
        if (out_rd !== 5'd3 || out_to_fp !== 1'b1) begin
            bad++; $display("FAIL order_head1 got=rd%0d/fp%b want=rd3/fp1", out_rd, out_to_fp);
        end
        cycle(1'b0, 2'b00, 32'd0, 5'd0, 1'b0, 1'b0);
        total++;
        if (dut_vec !== exp_vec()) begin bad++; $display("FAIL order_stable got=%h want=%h", dut_vec, exp_vec()); end
        cycle(1'b0, 2'b00, 32'd0, 5'd0, 1'b1, 1'b0);
        total++;
        if (dut_vec !== {1'b1, 32'hC000_0000, 5'd7, 1'b0, 1'b0, 8'd0}) begin
            bad++; $display("FAIL order_head2 got=%h want=%h", dut_vec, {1'b1, 32'hC000_0000, 5'd7, 1'b0, 1'b0, 8'd0});
        end
        cycle(1'b0, 2'b00, 32'd0, 5'd0, 1'b1, 1'b0);
        total++;
        if (out_valid !== 1'b0) begin bad++; $display("FAIL order_empty got=%b want=0", out_valid); end
    endtask

    task automatic test_back_to_back();
        int acc = 0;
        int cyc = 0;
        cycle(1'b1, 2'b01, 32'h1111_1111, 5'd1, 1'b0, 1'b0);
        cycle(1'b1, 2'b10, 32'h2222_2222, 5'd2, 1'b0, 1'b0);
        cycle(1'b1, 2'b01, 32'h3333_3333, 5'd9, 1'b1, 1'b0);
        total++;
        if (obs_ready !== 1'b0) begin bad++; $display("FAIL full_no_bypass got=%b want=0", obs_ready); end
        total++;
        if (dut_vec !== exp_vec() || q.size() != 1) begin
            bad++; $display("FAIL full_pop_only got=%h want=%h", dut_vec, exp_vec());
        end
        cycle(1'b1, 2'b01, 32'h3333_3333, 5'd9, 1'b0, 1'b0);
        total++;
        if (obs_ready !== 1'b1 || last_acc !== 1'b1) begin
            bad++; $display("FAIL full_next_accept got=%b want=1", obs_ready);
        end
        while (acc < 10 && cyc < 200) begin
            cycle(1'b1, 2'($urandom_range(1, 2)), $urandom, 5'($urandom), 1'($urandom), 1'b0);
            if (last_acc) acc++;
            cyc++;
            total++;
            if (obs_ready !== exp_ready || dut_vec !== exp_vec()) begin
                bad++; $display("FAIL b2b cyc=%0d got=%b/%h want=%b/%h", cyc, obs_ready, dut_vec, exp_ready, exp_vec());
            end
        end
        total++;
        if (acc != 10) begin bad++; $display("FAIL b2b_timeout got=%0d want=10", acc); end
        repeat (3) cycle(1'b0, 2'b00, 32'd0, 5'd0, 1'b1, 1'b0);
        total++;
        if (dut_vec !== exp_vec() || q.size() != 0) begin bad++; $display("FAIL b2b_drain got=%h want=%h", dut_vec, exp_vec()); end
    endtask

    task automatic test_illegal();
        int acc = 0;
        int cyc = 0;
        do_reset();
        @(negedge clk);
        cycle(1'b1, 2'b11, 32'hFFFF_FFFF, 5'd4, 1'b0, 1'b0);
        total++;
        if (dut_vec !== {1'b1, 32'd0, 5'd4, 1'b0, 1'b1, 8'd1}) begin
            bad++; $display("FAIL illegal_first got=%h want=%h", dut_vec, {1'b1, 32'd0, 5'd4, 1'b0, 1'b1, 8'd1});
        end
        while (acc < 299 && cyc < 1000) begin
            cycle(1'b1, ($urandom_range(0, 1) == 0) ? 2'b00 : 2'b11, $urandom, 5'($urandom), 1'b1, 1'b0);
            if (last_acc) acc++;
            cyc++;
        end
        total++;
        if (illegal_cnt !== 8'd255) begin bad++; $display("FAIL illegal_saturate got=%0d want=255", illegal_cnt); end
        total++;
        if (dut_vec !== exp_vec()) begin bad++; $display("FAIL illegal_model got=%h want=%h", dut_vec, exp_vec()); end
        cycle(1'b0, 2'b00, 32'd0, 5'd0, 1'b1, 1'b0);
    endtask

    task automatic test_flush();
        logic [7:0] cnt_before;
        do_reset();
        @(negedge clk);
        cycle(1'b1, 2'b11, 32'h5, 5'd1, 1'b0, 1'b0);
        cycle(1'b1, 2'b10, 32'h6, 5'd2, 1'b0, 1'b0);
        cnt_before = illegal_cnt;
        cycle(1'b1, 2'b11, 32'h7, 5'd3, 1'b1, 1'b1);
        total++;
        if (obs_ready !== 1'b0) begin bad++; $display("FAIL flush_ready got=%b want=0", obs_ready); end
        total++;
        if (out_valid !== 1'b0 || illegal_cnt !== 8'd1 || cnt_before !== 8'd1) begin
            bad++; $display("FAIL flush_state got=v%b/cnt%0d want=v0/cnt1", out_valid, illegal_cnt);
        end
        cycle(1'b1, 2'b01, 32'hABCD_0123, 5'd8, 1'b0, 1'b0);
        total++;
        if (dut_vec !== {1'b1, 32'hABCD_0123, 5'd8, 1'b0, 1'b0, 8'd1}) begin
            bad++; $display("FAIL flush_refill got=%h want=%h", dut_vec, {1'b1, 32'hABCD_0123, 5'd8, 1'b0, 1'b0, 8'd1});
        end
        cycle(1'b0, 2'b00, 32'd0, 5'd0, 1'b1, 1'b0);
    endtask

    task automatic test_async_reset();
        cycle(1'b1, 2'b11, 32'h9, 5'd6, 1'b0, 1'b0);
        #2;
        rst = 1'b1;
        q.delete(); ill = 0;
        #1;
        total++;
        if (dut_vec !== 48'd0 || in_ready !== 1'b1) begin
            bad++; $display("FAIL async_reset got=%h/%b want=%h/1", dut_vec, in_ready, 48'd0);
        end
        @(negedge clk);
        rst = 1'b0;
        cycle(1'b1, 2'b10, 32'h4049_0FDB, 5'd31, 1'b0, 1'b0);
        total++;
        if (obs_pre_valid !== 1'b0 || dut_vec !== {1'b1, 32'h4049_0FDB, 5'd31, 1'b1, 1'b0, 8'd0}) begin
            bad++; $display("FAIL post_reset got=%b/%h want=0/%h", obs_pre_valid, dut_vec, {1'b1, 32'h4049_0FDB, 5'd31, 1'b1, 1'b0, 8'd0});
        end
        cycle(1'b0, 2'b00, 32'd0, 5'd0, 1'b1, 1'b0);
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            cycle(1'($urandom), 2'($urandom), $urandom, 5'($urandom), 1'($urandom),
                  ($urandom_range(0, 19) == 0));
            total++;
            if (obs_ready !== exp_ready || dut_vec !== exp_vec()) begin
                bad++; $display("FAIL random i=%0d got=%b/%h want=%b/%h", i, obs_ready, dut_vec, exp_ready, exp_vec());
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_order();
        test_back_to_back();
        test_illegal();
        test_flush();
        test_async_reset();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
